uc_microc: RTL and testbench
============================

UC_MICROC -- requirements
Module: uc_microc

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset: reset asserted (0) forces reset state immediately; release is sampled on clk rising edge.
REQ-002 clk  input  1  system clock; all state updates on rising edge.
REQ-003 reset  input  1  asynchronous active-low reset.
REQ-004 Opcode  input  6  opcode field of the current instruction, from the microc datapath.
REQ-005 z  input  1  registered zero flag from the datapath.
REQ-006 s_inc  output  1  1 = PC+1, 0 = PC loads jump address.
REQ-007 s_inm  output  1  1 = register-file write data from immediate, 0 = from ALU.
REQ-008 we3  output  1  register-file write enable.
REQ-009 wez  output  1  zero-flag write enable.
REQ-010 Op  output  3  ALU operation select.
REQ-011 halted  output  1  1 while in HALT state.
REQ-012 illegal  output  1  sticky flag: an undefined opcode was executed.
REQ-013 instr_count  output  16  executed-instruction counter.
REQ-014 jump_count  output  8  taken-jump counter.

Function
REQ-015 The block SHALL implement a two-state FSM, RUN and HALT; RUN -> HALT on the rising edge at which Opcode==6'b111111 in RUN; HALT is left only via reset.
REQ-016 In RUN, the control outputs SHALL be a combinational decode of Opcode and z, valid in the same cycle (zero latency):
- 1xxxxx except 111111 (ALU): s_inc=1, s_inm=0, we3=1, wez=1, Op=Opcode[4:2].
- 01xxxx (LI): s_inc=1, s_inm=1, we3=1, wez=0, Op=000.
- 000000 (J): s_inc=0, all other controls 0.
- 000001 (JZ): s_inc=~z, all other controls 0.
- 000010 (JNZ): s_inc=z, all other controls 0.
- 111111 (HALT): s_inc=0, all other controls 0.
- 000011..001111 (illegal): executes as NOP, s_inc=1, all other controls 0.
REQ-017 In HALT, outputs SHALL be s_inc=0, s_inm=0, we3=0, wez=0, Op=000, independent of Opcode and z; programs SHALL encode HALT with its own address in the address field so the PC holds.
REQ-018 illegal SHALL be set on the rising edge at which an illegal opcode is decoded in RUN, and SHALL stay set until reset.
REQ-019 A jump is taken when the decode in RUN gives s_inc=0 for J, JZ or JNZ; HALT is not a taken jump.
REQ-020 z SHALL be used only as sampled in the current cycle; an ALU write of z and a following JZ/JNZ in the next cycle SHALL see the updated z.

Reset
REQ-021 While reset=0: state=RUN, halted=0, illegal=0, instr_count=0, jump_count=0, and s_inc=0, s_inm=0, we3=0, wez=0, Op=000.
REQ-022 Reset asserted mid-HALT or mid-loop SHALL return the block to RUN with all counters and flags cleared, without waiting for a clock edge.

Configuration
REQ-023 Macro UC_PERF_CNT_EN: when defined, instr_count and jump_count SHALL be implemented; when undefined, both SHALL be tied to 0 with no counter flops.
REQ-024 With UC_PERF_CNT_EN defined, instr_count SHALL increment by 1 on every rising edge in RUN (HALT included) and saturate at 16'hFFFF; it SHALL hold in HALT.
REQ-025 With UC_PERF_CNT_EN defined, jump_count SHALL increment by 1 on each taken jump in RUN and wrap from 8'hFF to 8'h00.

Verification
REQ-026 Reset: hold reset=0 with Opcode=6'b100100 -> all controls 0, counters 0; release -> s_inc=1, we3=1, wez=1, Op=001.
REQ-027 Decode sweep: apply all 64 Opcodes with z=0 and with z=1 -> outputs match REQ-016 exactly; 6'b000001 with z=1 -> s_inc=0; 6'b000010 with z=1 -> s_inc=1.
REQ-028 Loop program: LI x4, then (ALU add, ALU sub, JNZ) with z=0,0,1 across two iterations -> jump_count=1; instr_count=10 after 10 edges.
REQ-029 HALT: Opcode=6'b111111 -> halted=1 on the next edge; then apply Opcode=6'b100000 -> controls stay 0 and instr_count holds.
REQ-030 Illegal opcode: Opcode=6'b000111 for one cycle -> s_inc=1, illegal=1 after the edge and still 1 after 5 further valid instructions; reset -> illegal=0.
REQ-031 Saturation and wrap (UC_PERF_CNT_EN): run 65540 instructions -> instr_count=16'hFFFF; issue 257 J -> jump_count=8'h01; without the macro -> both counters 0 throughout.

Source files
------------

// File: rtl/uc_microc.sv
// ---------------------------------------------------------------------------
// uc_microc -- control unit for the microc single-cycle datapath.
//
// Decodes the 6-bit opcode (plus the registered zero flag) into the datapath
// control signals with zero latency, and keeps a small amount of state:
// a RUN/HALT state machine, a sticky illegal-opcode flag and, optionally,
// two performance counters.
//
// Ports:
//   clk          in   system clock, all state updates on the rising edge
//   reset        in   asynchronous active-low reset
//   Opcode[5:0]  in   opcode field of the current instruction
//   z            in   registered zero flag from the datapath
//   s_inc        out  1 = PC+1, 0 = PC loads the jump address
//   s_inm        out  1 = register-file write data from immediate
//   we3          out  register-file write enable
//   wez          out  zero-flag write enable
//   Op[2:0]      out  ALU operation select
//   halted       out  1 while in HALT
//   illegal      out  sticky: an undefined opcode was executed
//   instr_count  out  executed-instruction counter (saturating)
//   jump_count   out  taken-jump counter (wrapping)
//
// Configuration macro:
//   UC_PERF_CNT_EN  when defined, instr_count and jump_count are real
//                   counters; otherwise both are tied to zero and no
//                   counter flops exist.
// ---------------------------------------------------------------------------
module uc_microc (
  input  logic        clk,
  input  logic        reset,
  input  logic [5:0]  Opcode,
  input  logic        z,
  output logic        s_inc,
  output logic        s_inm,
  output logic        we3,
  output logic        wez,
  output logic [2:0]  Op,
  output logic        halted,
  output logic        illegal,
  output logic [15:0] instr_count,
  output logic [7:0]  jump_count
);

  typedef enum logic {
    ST_RUN  = 1'b0,
    ST_HALT = 1'b1
  } state_t;

  localparam logic [5:0] OPC_J    = 6'b000000;
  localparam logic [5:0] OPC_JZ   = 6'b000001;
  localparam logic [5:0] OPC_JNZ  = 6'b000010;
  localparam logic [5:0] OPC_HALT = 6'b111111;

  state_t state_q, state_d;
  logic   illegal_q, illegal_d;

  // Decoded controls before gating by state/reset.
  logic       dec_s_inc;
  logic       dec_s_inm;
  logic       dec_we3;
  logic       dec_wez;
  logic [2:0] dec_op;
  logic       dec_halt;
  logic       dec_illegal;

  // Outputs are only live while the reset pin is released and we are in
  // RUN; looking at the reset pin directly keeps the controls at zero
  // during reset regardless of the opcode on the bus.
  logic run_active;

  assign run_active = reset && (state_q == ST_RUN);

  // Pure opcode decode. The HALT encoding lives inside the ALU range
  // (1xxxxx), so it is tested first.
  always_comb begin
    dec_s_inc   = 1'b0;
    dec_s_inm   = 1'b0;
    dec_we3     = 1'b0;
    dec_wez     = 1'b0;
    dec_op      = 3'b000;
    dec_halt    = 1'b0;
    dec_illegal = 1'b0;

    if (Opcode == OPC_HALT) begin
      dec_halt = 1'b1;
    end else if (Opcode[5]) begin
      dec_s_inc = 1'b1;
      dec_we3   = 1'b1;
      dec_wez   = 1'b1;
      dec_op    = Opcode[4:2];
    end else if (Opcode[4]) begin
      dec_s_inc = 1'b1;
      dec_s_inm = 1'b1;
      dec_we3   = 1'b1;
    end else if (Opcode == OPC_J) begin
      dec_s_inc = 1'b0;
    end else if (Opcode == OPC_JZ) begin
      dec_s_inc = ~z;
    end else if (Opcode == OPC_JNZ) begin
      dec_s_inc = z;
    end else begin
      // 000011..001111: undefined, executed as a NOP.
      dec_s_inc   = 1'b1;
      dec_illegal = 1'b1;
    end
  end

  always_comb begin
    s_inc = run_active & dec_s_inc;
    s_inm = run_active & dec_s_inm;
    we3   = run_active & dec_we3;
    wez   = run_active & dec_wez;
    Op    = run_active ? dec_op : 3'b000;
  end

  // Next-state logic: HALT is absorbing, only reset brings us back.
  always_comb begin
    state_d   = state_q;
    illegal_d = illegal_q;
    if (state_q == ST_RUN) begin
      if (dec_halt) begin
        state_d = ST_HALT;
      end
      if (dec_illegal) begin
        illegal_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= ST_RUN;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      illegal_q <= illegal_d;
    end
  end

  assign halted  = (state_q == ST_HALT);
  assign illegal = illegal_q;

`ifdef UC_PERF_CNT_EN
  logic [15:0] instr_count_q, instr_count_d;
  logic [7:0]  jump_count_q, jump_count_d;
  logic        is_jump_opc;
  logic        jump_taken;

  // J/JZ/JNZ are 0000xx with xx != 11; a taken jump is one of those with
  // the PC not incrementing. HALT also has s_inc=0 but is excluded here.
  assign is_jump_opc = (Opcode[5:2] == 4'b0000) && (Opcode[1:0] != 2'b11);
  assign jump_taken  = run_active && is_jump_opc && !dec_s_inc;

  // Every edge spent in RUN retires one instruction, including the HALT
  // itself; the count sticks at all-ones instead of wrapping.
  always_comb begin
    instr_count_d = instr_count_q;
    jump_count_d  = jump_count_q;
    if (run_active && (instr_count_q != 16'hFFFF)) begin
      instr_count_d = instr_count_q + 16'd1;
    end
    if (jump_taken) begin
      jump_count_d = jump_count_q + 8'd1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      instr_count_q <= 16'd0;
      jump_count_q  <= 8'd0;
    end else begin
      instr_count_q <= instr_count_d;
      jump_count_q  <= jump_count_d;
    end
  end

  assign instr_count = instr_count_q;
  assign jump_count  = jump_count_q;
`else
  assign instr_count = 16'd0;
  assign jump_count  = 8'd0;
`endif

endmodule

// File: tb/tb_uc_microc.sv
// ---------------------------------------------------------------------------
// tb_uc_microc -- directed self-checking bench for uc_microc.
//
// Inputs are driven on the falling edge of clk and outputs are sampled 1ns
// later, away from the rising edge where state changes. Expected counter
// values depend on whether UC_PERF_CNT_EN is defined for the build.
// ---------------------------------------------------------------------------
module tb_uc_microc;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [5:0]  Opcode = 6'b000000;
  logic        z = 1'b0;
  logic        s_inc;
  logic        s_inm;
  logic        we3;
  logic        wez;
  logic [2:0]  Op;
  logic        halted;
  logic        illegal;
  logic [15:0] instr_count;
  logic [7:0]  jump_count;

  int testCount = 0;
  int failCount = 0;

`ifdef UC_PERF_CNT_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  localparam logic [5:0] LI   = 6'b010000;
  localparam logic [5:0] ADD  = 6'b100000;
  localparam logic [5:0] SUB  = 6'b100100;
  localparam logic [5:0] J    = 6'b000000;
  localparam logic [5:0] JZ   = 6'b000001;
  localparam logic [5:0] JNZ  = 6'b000010;
  localparam logic [5:0] HALT = 6'b111111;

  // Control bundle order: {s_inc, s_inm, we3, wez, Op[2:0]}
  localparam logic [6:0] CTRL_OFF = 7'b0000000;

  always #5 clk = ~clk;

  uc_microc dut (
    .clk         (clk),
    .reset       (reset),
    .Opcode      (Opcode),
    .z           (z),
    .s_inc       (s_inc),
    .s_inm       (s_inm),
    .we3         (we3),
    .wez         (wez),
    .Op          (Op),
    .halted      (halted),
    .illegal     (illegal),
    .instr_count (instr_count),
    .jump_count  (jump_count)
  );

  // Reference decode written straight from the opcode table.
  function automatic logic [6:0] expDecode(input logic [5:0] op, input logic zz);
    logic [6:0] r;
    if (op == 6'b111111)      r = 7'b0000000;
    else if (op[5])           r = {4'b1011, op[4:2]};
    else if (op[4])           r = 7'b1110000;
    else if (op == 6'b000000) r = 7'b0000000;
    else if (op == 6'b000001) r = {~zz, 6'b000000};
    else if (op == 6'b000010) r = {zz, 6'b000000};
    else                      r = 7'b1000000;
    return r;
  endfunction

  task automatic checkVal(input string tag, input logic [15:0] observed,
                          input logic [15:0] expected);
    testCount++;
    assert (observed === expected) else begin
      failCount++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic checkOutput(input string tag, input logic [6:0] expected);
    checkVal(tag, {9'b0, s_inc, s_inm, we3, wez, Op}, {9'b0, expected});
  endtask

  // Drive inputs and let the combinational decode settle.
  task automatic applyStimulus(input logic [5:0] op, input logic zz);
    Opcode = op;
    z      = zz;
    #1;
  endtask

  // Short reset pulse within the low phase of clk; no edge sees it.
  task automatic resetPulse();
    @(negedge clk);
    reset = 1'b0;
    #2;
    reset = 1'b1;
  endtask

  logic [5:0] progOp [10];
  logic       progZ  [10];

  initial begin
    $display("[TB] start, PERF=%0d", PERF);

    // Reset held with an ALU opcode on the bus: everything quiet.
    reset  = 1'b0;
    Opcode = SUB;
    z      = 1'b0;
    #1;
    checkOutput("reset_ctrl", CTRL_OFF);
    checkVal("reset_halted", {15'b0, halted}, 16'd0);
    checkVal("reset_illegal", {15'b0, illegal}, 16'd0);
    checkVal("reset_icount", instr_count, 16'd0);
    checkVal("reset_jcount", {8'b0, jump_count}, 16'd0);
    @(posedge clk);
    #1;
    checkOutput("reset_ctrl_after_edge", CTRL_OFF);
    checkVal("reset_icount_after_edge", instr_count, 16'd0);

    @(negedge clk);
    reset = 1'b1;
    #1;
    checkOutput("release_sub", 7'b1011001);

    // Decode sweep, HALT excluded here so the sweep stays in RUN.
    for (int i = 0; i < 63; i++) begin
      @(negedge clk);
      applyStimulus(6'(i), 1'b0);
      checkOutput($sformatf("sweep_op%02h_z0", i), expDecode(6'(i), 1'b0));
      applyStimulus(6'(i), 1'b1);
      checkOutput($sformatf("sweep_op%02h_z1", i), expDecode(6'(i), 1'b1));
    end
    @(negedge clk);
    applyStimulus(JZ, 1'b1);
    checkOutput("jz_z1_taken", 7'b0000000);
    applyStimulus(JNZ, 1'b1);
    checkOutput("jnz_z1_fallthrough", 7'b1000000);

    // Loop program: 4 LI, then two (ADD, SUB, JNZ) passes; the first JNZ
    // is taken (z=0), the second falls through (z=1).
    progOp = '{LI, LI, LI, LI, ADD, SUB, JNZ, ADD, SUB, JNZ};
    progZ  = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 1};
    resetPulse();
    for (int i = 0; i < 10; i++) begin
      applyStimulus(progOp[i], progZ[i]);
      if (i == 6) checkOutput("loop_jnz_taken", 7'b0000000);
      if (i == 9) checkOutput("loop_jnz_exit", 7'b1000000);
      @(negedge clk);
    end
    checkVal("loop_icount", instr_count, PERF ? 16'd10 : 16'd0);
    checkVal("loop_jcount", {8'b0, jump_count}, PERF ? 16'd1 : 16'd0);
    checkVal("loop_halted", {15'b0, halted}, 16'd0);

    // HALT: controls off, state latches on the edge, counter freezes.
    resetPulse();
    applyStimulus(HALT, 1'b0);
    checkOutput("halt_ctrl", CTRL_OFF);
    checkVal("halt_before_edge", {15'b0, halted}, 16'd0);
    @(negedge clk);
    checkVal("halt_after_edge", {15'b0, halted}, 16'd1);
    checkVal("halt_icount", instr_count, PERF ? 16'd1 : 16'd0);
    applyStimulus(ADD, 1'b0);
    checkOutput("halt_ignores_add", CTRL_OFF);
    @(negedge clk);
    @(negedge clk);
    checkOutput("halt_still_off", CTRL_OFF);
    checkVal("halt_icount_hold", instr_count, PERF ? 16'd1 : 16'd0);
    checkVal("halt_jcount", {8'b0, jump_count}, 16'd0);
    // Asynchronous exit from HALT, no clock edge involved.
    reset = 1'b0;
    #1;
    checkVal("halt_async_reset", {15'b0, halted}, 16'd0);
    checkOutput("halt_async_ctrl", CTRL_OFF);
    checkVal("halt_async_icount", instr_count, 16'd0);
    reset = 1'b1;
    #1;
    checkOutput("halt_exit_add", 7'b1011000);

    // Illegal opcode: NOP behaviour, sticky flag.
    resetPulse();
    applyStimulus(6'b000111, 1'b1);
    checkOutput("illegal_nop", 7'b1000000);
    checkVal("illegal_before_edge", {15'b0, illegal}, 16'd0);
    @(negedge clk);
    checkVal("illegal_set", {15'b0, illegal}, 16'd1);
    applyStimulus(LI, 1'b0);   @(negedge clk);
    applyStimulus(ADD, 1'b0);  @(negedge clk);
    applyStimulus(J, 1'b0);    @(negedge clk);
    applyStimulus(JZ, 1'b0);   @(negedge clk);
    applyStimulus(LI, 1'b0);   @(negedge clk);
    checkVal("illegal_sticky", {15'b0, illegal}, 16'd1);
    checkVal("illegal_jcount", {8'b0, jump_count}, PERF ? 16'd1 : 16'd0);
    checkVal("illegal_icount", instr_count, PERF ? 16'd6 : 16'd0);
    reset = 1'b0;
    #1;
    checkVal("illegal_cleared", {15'b0, illegal}, 16'd0);
    checkVal("illegal_jcount_cleared", {8'b0, jump_count}, 16'd0);
    reset = 1'b1;

    // Counter saturation and wrap.
    resetPulse();
    applyStimulus(ADD, 1'b0);
    repeat (65540) @(negedge clk);
    checkVal("sat_icount", instr_count, PERF ? 16'hFFFF : 16'd0);
    applyStimulus(J, 1'b0);
    repeat (257) @(negedge clk);
    checkVal("wrap_jcount", {8'b0, jump_count}, PERF ? 16'd1 : 16'd0);
    checkVal("sat_icount_hold", instr_count, PERF ? 16'hFFFF : 16'd0);

    $display("[TB] %0d tests run, %0d failed", testCount, failCount);
    $finish;
  end

endmodule
